watchdog_timer: RTL and testbench

- Supervisory counter that issues a reset request when software/logic stops servicing it within TIMEOUT cycles.
- Its reset_request output is the reset_in source for synchronous_reset_timer, which stretches it into the system reset.
- Provides an early-warning flag, a sticky expiry flag and the live count.

---
 rtl/watchdog_pkg.sv | 40 ++++
 rtl/watchdog_counter.sv | 30 +++
 rtl/watchdog_timer.sv | 140 ++++++++++++++
 tb/tb_watchdog_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog timer slice.
//   state_t    : FSM state encoding (IDLE, RUN, FIRE)
//   clog2      : width helper, never returns less than 1
//   params_ok  : parameter legality check used at elaboration
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned     w;
    longint unsigned v;
    w = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // MIN_KICK only matters when the window feature is built in.
  function automatic bit params_ok(input int unsigned timeout,
                                   input int unsigned warn_at,
                                   input int unsigned pulse,
                                   input int unsigned min_kick,
                                   input bit          window);
    bit ok;
    ok = (timeout >= 4) && (timeout <= (1 << 24)) &&
         (warn_at >= 1) && (warn_at < timeout) &&
         (pulse >= 1);
    if (window)
      ok = ok && (min_kick >= 1) && (min_kick < warn_at);
    return ok;
  endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Parameterised up-counter with synchronous clear and increment enable.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (wins over inc)
//   inc      : increment by one
//   value    : current count
//   at_term  : high while value == TERM
module watchdog_counter #(
  parameter int unsigned    W    = 8,
  parameter logic [W-1:0]   TERM = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (clear)
      value <= '0;
    else if (inc)
      value <= value + W'(1);
  end

  assign at_term = (value == TERM);

endmodule

// File: rtl/watchdog_timer.sv
// Supervisory watchdog: fires a PULSE-cycle reset_request when not kicked
// within TIMEOUT cycles while enabled.
//   clk           : system clock
//   reset_in      : asynchronous active-high reset of all state
//   enable        : arms the watchdog while high
//   kick          : single-cycle service strobe, restarts the count
//   reset_request : high for exactly PULSE cycles on expiry
//   warning       : high while armed and count >= WARN_AT
//   expired       : sticky, set on first fire, cleared only by reset_in
//   count         : live count (0 in IDLE and FIRE)
// Optional macro WATCHDOG_WINDOW_EN: kicks with count < MIN_KICK also fire.
module watchdog_timer
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned WARN_AT  = 750,
  parameter int unsigned PULSE    = 4,
  parameter int unsigned MIN_KICK = 100
) (
  input  logic                              clk,
  input  logic                              reset_in,
  input  logic                              enable,
  input  logic                              kick,
  output logic                              reset_request,
  output logic                              warning,
  output logic                              expired,
  output logic [clog2(TIMEOUT + 1) - 1:0]   count
);

  localparam int unsigned CW = clog2(TIMEOUT + 1);
  localparam int unsigned PW = clog2(PULSE + 1);

`ifdef WATCHDOG_WINDOW_EN
  localparam bit WINDOW = 1'b1;
  localparam logic [CW-1:0] MIN_V = CW'(MIN_KICK);
`else
  localparam bit WINDOW = 1'b0;
`endif

  localparam logic [CW-1:0] WARN_V = CW'(WARN_AT);

  if (!params_ok(TIMEOUT, WARN_AT, PULSE, MIN_KICK, WINDOW)) begin : g_bad_params
    $error("watchdog_timer: illegal parameter combination");
  end

  state_t         state_q, state_d;
  logic           cnt_clear, cnt_inc, cnt_term;
  logic           pulse_clear, pulse_inc, pulse_term;
  logic [PW-1:0]  pulse_value;
  logic           pulse_value_unused;

  watchdog_counter #(
    .W    (CW),
    .TERM (CW'(TIMEOUT - 1))
  ) u_main_cnt (
    .clk     (clk),
    .rst     (reset_in),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .value   (count),
    .at_term (cnt_term)
  );

  watchdog_counter #(
    .W    (PW),
    .TERM (PW'(PULSE - 1))
  ) u_pulse_cnt (
    .clk     (clk),
    .rst     (reset_in),
    .clear   (pulse_clear),
    .inc     (pulse_inc),
    .value   (pulse_value),
    .at_term (pulse_term)
  );

  // Only the pulse counter's terminal flag is used.
  assign pulse_value_unused = ^pulse_value;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Counters clear by default; they only run in the one branch that advances them.
  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b1;
    cnt_inc     = 1'b0;
    pulse_clear = 1'b1;
    pulse_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable)
          state_d = RUN;
      end
      RUN: begin
        if (!enable)
          state_d = IDLE;
`ifdef WATCHDOG_WINDOW_EN
        else if (kick) begin
          if (count < MIN_V)
            state_d = FIRE;
        end
`else
        else if (kick)
          state_d = RUN;
`endif
        else if (cnt_term)
          state_d = FIRE;
        else begin
          cnt_clear = 1'b0;
          cnt_inc   = 1'b1;
        end
      end
      FIRE: begin
        if (pulse_term)
          state_d = enable ? RUN : IDLE;
        else begin
          pulse_clear = 1'b0;
          pulse_inc   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in)
      expired <= 1'b0;
    else if (state_d == FIRE)
      expired <= 1'b1;
  end

  // Decoded from the registered state so reset_in clears it without a clock.
  assign reset_request = (state_q == FIRE);
  assign warning       = (state_q == RUN) && (count >= WARN_V);

endmodule

// File: tb/tb_watchdog_timer.sv
// Scoreboard bench for watchdog_timer with TIMEOUT=8, WARN_AT=6, PULSE=3,
// MIN_KICK=2. Define WATCHDOG_WINDOW_EN for both files to cover window mode.
module tb_watchdog_timer;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       enable = 1'b0;
  logic       kick = 1'b0;
  logic       reset_request, warning, expired;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    cnt;
    bit    warn;
    bit    rr;
    bit    exp;
    string nm;
  } exp_t;

  exp_t exp_q[$];

  watchdog_timer #(
    .TIMEOUT  (8),
    .WARN_AT  (6),
    .PULSE    (3),
    .MIN_KICK (2)
  ) dut (
    .clk           (clk),
    .reset_in      (reset_in),
    .enable        (enable),
    .kick          (kick),
    .reset_request (reset_request),
    .warning       (warning),
    .expired       (expired),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // Drive inputs for the coming edge and queue the outputs expected after it.
  task automatic step(input bit en, input bit kk, input int c, input bit w,
                      input bit r, input bit e, input string nm);
    @(negedge clk);
    enable = en;
    kick   = kk;
    exp_q.push_back('{c, w, r, e, nm});
  endtask

  task automatic run_counts(input int from, input int to, input bit e, input string nm);
    for (int c = from; c <= to; c++)
      step(1'b1, 1'b0, c, (c >= 6), 1'b0, e, nm);
  endtask

  // Monitor: compares each post-edge output set with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.nm, "_count"},   int'(count),         e.cnt);
        check({e.nm, "_warning"}, int'(warning),       int'(e.warn));
        check({e.nm, "_rreq"},    int'(reset_request), int'(e.rr));
        check({e.nm, "_expired"}, int'(expired),       int'(e.exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit win_exp;

    // Reset state, observed while reset is held.
    #3;
    check("rst_count",   int'(count),         0);
    check("rst_warning", int'(warning),       0);
    check("rst_rreq",    int'(reset_request), 0);
    check("rst_expired", int'(expired),       0);
    @(negedge clk);
    reset_in = 1'b0;

    // 1: free run to timeout, 3-cycle pulse, enable held so RUN resumes.
    step(1, 0, 0, 0, 0, 0, "t1_run_entry");
    run_counts(1, 7, 0, "t1_run");
    step(1, 0, 0, 0, 1, 1, "t1_fire0");
    step(1, 0, 0, 0, 1, 1, "t1_fire1");
    step(1, 0, 0, 0, 1, 1, "t1_fire2");
    step(1, 0, 0, 0, 0, 1, "t1_rerun");

    // 2: periodic kick at count 5; never warns or fires.
    for (int k = 0; k < 8; k++) begin
      run_counts(1, 5, 1, "t2_run");
      step(1, 1, 0, 0, 0, 1, "t2_kick");
    end

    // 3a: kick on terminal count prevents firing.
    run_counts(1, 7, 1, "t3_run");
    step(1, 1, 0, 0, 0, 1, "t3_term_kick");
    // 3b: kick one cycle late lands in FIRE and is ignored.
    run_counts(1, 7, 1, "t3_run2");
    step(1, 0, 0, 0, 1, 1, "t3_fire0");
    step(1, 1, 0, 0, 1, 1, "t3_fire1");
    step(1, 0, 0, 0, 1, 1, "t3_fire2");
    step(1, 0, 0, 0, 0, 1, "t3_rerun");

    // 4: enable dropped in second pulse cycle; pulse completes, then IDLE.
    run_counts(1, 7, 1, "t4_run");
    step(1, 0, 0, 0, 1, 1, "t4_fire0");
    step(1, 0, 0, 0, 1, 1, "t4_fire1");
    step(0, 0, 0, 0, 1, 1, "t4_fire2");
    step(0, 0, 0, 0, 0, 1, "t4_idle");
    step(0, 1, 0, 0, 0, 1, "t4_idle_kick");
    step(0, 0, 0, 0, 0, 1, "t4_idle_hold");

    // 5: asynchronous reset in the middle of FIRE.
    step(1, 0, 0, 0, 0, 1, "t5_run_entry");
    run_counts(1, 7, 1, "t5_run");
    step(1, 0, 0, 0, 1, 1, "t5_fire0");
    @(negedge clk);
    check("t5_rreq_before_rst", int'(reset_request), 1);
    #1 reset_in = 1'b1;
    #1;
    check("t5_async_rreq",    int'(reset_request), 0);
    check("t5_async_expired", int'(expired),       0);
    check("t5_async_count",   int'(count),         0);
    @(negedge clk);
    reset_in = 1'b0;
    enable   = 1'b0;
    step(0, 0, 0, 0, 0, 0, "t5_idle");
    step(0, 0, 0, 0, 0, 0, "t5_idle_hold");

    // 6: kick at count 1 (window violation when enabled), then kick at 2.
    step(1, 0, 0, 0, 0, 0, "t6_run_entry");
    step(1, 0, 1, 0, 0, 0, "t6_run");
`ifdef WATCHDOG_WINDOW_EN
    step(1, 1, 0, 0, 1, 1, "t6_early_fire0");
    step(1, 0, 0, 0, 1, 1, "t6_fire1");
    step(1, 0, 0, 0, 1, 1, "t6_fire2");
    step(1, 0, 0, 0, 0, 1, "t6_rerun");
    win_exp = 1'b1;
`else
    step(1, 1, 0, 0, 0, 0, "t6_kick1_ok");
    win_exp = 1'b0;
`endif
    run_counts(1, 2, win_exp, "t6_run2");
    step(1, 1, 0, 0, 0, win_exp, "t6_kick2_ok");
    step(1, 0, 1, 0, 0, win_exp, "t6_after_kick");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
